gb_oam_dma: RTL and testbench

- Responder side of the PPU's DMA request: the PPU register file pulses dma_start and drives dma_start_addr when the CPU writes 0xFF46.
- This block copies 160 bytes from {src_hi, 8'h00}..{src_hi, 8'h9F} into OAM (0xFE00-0xFE9F), one byte per M-cycle.
- It owns the system read port while active and drives the OAM write port.
- dma_active goes to the bus arbiter, which blocks CPU non-HRAM access during a transfer.

---
 rtl/gb_oam_dma.sv | 66 ++++++
 tb/tb_gb_oam_dma.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/gb_oam_dma.sv
// gb_oam_dma: OAM DMA engine, copies NUM_BYTES from {src_hi,00} to OAM one byte per M-cycle
// Ports: clk_m/reset (async, active-high); dma_start/dma_start_addr request from the PPU
// register block; rd_en/src_addr/rd_data system read port (1-cycle read latency);
// oam_wren/oam_addr/oam_data OAM write port; dma_active to the bus arbiter.
module gb_oam_dma #(
  parameter int NUM_BYTES = 160,
  parameter bit ECHO_FOLD = 1'b1
) (
  input  logic        clk_m,
  input  logic        reset,
  input  logic        dma_start,
  input  logic [15:0] dma_start_addr,
  input  logic [7:0]  rd_data,
  output logic        rd_en,
  output logic [15:0] src_addr,
  output logic        oam_wren,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        dma_active
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;
  localparam logic [7:0] LAST  = 8'(NUM_BYTES - 1);
  logic [1:0] state_q, state_d;
  logic [7:0] src_hi_q, src_hi_d, rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d, hi_in;
  logic       wr_pend_q, wr_pend_d, xfer, unused_lo;
  assign unused_lo = ^dma_start_addr[7:0];
  assign xfer = state_q == XFER;
  // Echo RAM region 0xE0-0xFF mirrors 0xC0-0xDF
  assign hi_in = (ECHO_FOLD && dma_start_addr[15:8] > 8'hDF) ? dma_start_addr[15:8] - 8'h20
                                                               : dma_start_addr[15:8];
  always_comb begin
    // The read issued this cycle is always written next cycle, even across a restart
    wr_pend_d = xfer;
    wr_idx_d  = xfer ? rd_idx_q : wr_idx_q;
    src_hi_d  = dma_start ? hi_in : src_hi_q;
    state_d   = dma_start ? START :
                state_q == START ? XFER :
                xfer ? (rd_idx_q == LAST ? DRAIN : XFER) : IDLE;
    rd_idx_d  = (dma_start || !xfer) ? 8'd0 :
                rd_idx_q == LAST ? rd_idx_q : rd_idx_q + 8'd1;
  end
  always_ff @(posedge clk_m or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      src_hi_q  <= '0;
      rd_idx_q  <= '0;
      wr_idx_q  <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_hi_q  <= src_hi_d;
      rd_idx_q  <= rd_idx_d;
      wr_idx_q  <= wr_idx_d;
      wr_pend_q <= wr_pend_d;
    end
  end
  assign rd_en      = xfer;
  assign src_addr   = xfer ? {src_hi_q, rd_idx_q} : 16'h0000;
  assign oam_wren   = wr_pend_q;
  assign oam_addr   = wr_idx_q;
  assign oam_data   = wr_pend_q ? rd_data : 8'h00;
  assign dma_active = state_q != IDLE;
endmodule

// File: tb/tb_gb_oam_dma.sv
// tb_gb_oam_dma: randomized scoreboard bench for gb_oam_dma
module tb_gb_oam_dma;
  logic        clk_m = 1'b0;
  logic        reset = 1'b1;
  logic        dma_start = 1'b0;
  logic [15:0] dma_start_addr = 16'h0000;
  logic [7:0]  rd_data = 8'h00;
  logic        rd_en, oam_wren, dma_active;
  logic [15:0] src_addr;
  logic [7:0]  oam_addr, oam_data;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          act_cycles = 0;
  logic [15:0] exp_rd[$];
  logic [15:0] exp_wr[$];

  gb_oam_dma dut (
    .clk_m(clk_m), .reset(reset), .dma_start(dma_start), .dma_start_addr(dma_start_addr),
    .rd_data(rd_data), .rd_en(rd_en), .src_addr(src_addr), .oam_wren(oam_wren),
    .oam_addr(oam_addr), .oam_data(oam_data), .dma_active(dma_active)
  );

  always #5 clk_m = ~clk_m;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ {a[11:8], a[15:12]};
  endfunction

  always @(posedge clk_m) if (rd_en) rd_data <= mem_f(src_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a transfer reads nr bytes and writes nw bytes from the folded source page
  task automatic push_xfer(input logic [15:0] a, input int nr, input int nw);
    logic [7:0] h;
    h = a[15:8] > 8'hDF ? a[15:8] - 8'h20 : a[15:8];
    for (int i = 0; i < nr; i++) exp_rd.push_back({h, 8'(i)});
    for (int i = 0; i < nw; i++) exp_wr.push_back({8'(i), mem_f({h, 8'(i)})});
  endtask

  task automatic pulse(input logic [15:0] a);
    @(posedge clk_m); #1;
    dma_start = 1'b1;
    dma_start_addr = a;
    @(posedge clk_m); #1;
    dma_start = 1'b0;
    dma_start_addr = 16'($urandom);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (dma_active && n < bound) begin
      @(posedge clk_m); #1;
      n++;
    end
    chk("idle_timeout", dma_active, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_src_addr"}, src_addr, 0);
    chk({tag, "_oam_wren"}, oam_wren, 0);
    chk({tag, "_oam_addr"}, oam_addr, 0);
    chk({tag, "_oam_data"}, oam_data, 0);
    chk({tag, "_active"}, dma_active, 0);
  endtask

  always @(negedge clk_m) if (!reset) begin
    if (dma_active) act_cycles++;
    if (rd_en) begin
      if (exp_rd.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_unexpected: got src_addr %0h expected no read", src_addr);
      end else chk("src_addr", src_addr, exp_rd.pop_front());
    end
    if (oam_wren) begin
      if (exp_wr.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr_unexpected: got %0h/%0h expected no write", oam_addr, oam_data);
      end else chk("oam_write", {oam_addr, oam_data}, exp_wr.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, nr;
    int pts[6];
    logic [15:0] a1, a2;
    repeat (3) @(posedge clk_m); #1;
    chk_zero("reset");
    dma_start = 1'b1;
    @(posedge clk_m); #1;
    dma_start = 1'b0;
    chk("start_in_reset", dma_active, 0);
    reset = 1'b0;
    @(posedge clk_m); #1;
    // basic transfer
    act_cycles = 0;
    push_xfer(16'hC100, 160, 160);
    pulse(16'hC100);
    lat = 0;
    while (!rd_en && lat < 10) begin
      @(negedge clk_m);
      lat++;
    end
    chk("first_rd_latency", lat, 2);
    wait_idle(400);
    chk("basic_active", act_cycles, 162);
    // echo fold with ignored low byte
    act_cycles = 0;
    push_xfer(16'hFE37, 160, 160);
    pulse(16'hFE37);
    wait_idle(400);
    chk("echo_active", act_cycles, 162);
    // restarts: byte 50, DRAIN back-to-back, then random points
    pts = '{51, 162, 2, 0, 0, 0};
    for (int k = 3; k < 6; k++) pts[k] = int'($urandom_range(2, 162));
    foreach (pts[k]) begin
      n = pts[k];
      a1 = 16'($urandom);
      a2 = 16'($urandom);
      nr = n - 1 > 160 ? 160 : n - 1;
      act_cycles = 0;
      push_xfer(a1, nr, nr);
      push_xfer(a2, 160, 160);
      pulse(a1);
      repeat (n - 2) @(posedge clk_m);
      pulse(a2);
      wait_idle(400);
      chk("restart_active", act_cycles, n + 162);
    end
    // async reset during read 80
    a1 = 16'($urandom);
    push_xfer(a1, 80, 79);
    pulse(a1);
    repeat (81) @(posedge clk_m);
    #2 reset = 1'b1;
    #1 chk_zero("async_reset");
    @(posedge clk_m); #1;
    reset = 1'b0;
    act_cycles = 0;
    push_xfer(16'hC000, 160, 160);
    pulse(16'hC000);
    wait_idle(400);
    chk("after_reset_active", act_cycles, 162);
    repeat (3) @(posedge clk_m); #1;
    chk("rd_left", exp_rd.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
